// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a shared valid/ready memory port.
// A watchdog terminates slave accesses that never complete and returns ERR_DATA.
module bus_arbiter #(
   parameter int          TIMEOUT  = 64,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        err,
   output logic        err_master
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t          r_state, w_state_n;
   logic            r_last;
   logic            r_err_master;
   logic [CW-1:0]   r_cnt;
   logic            w_gnt;
   logic            w_cur;
   logic            w_own_valid;
   logic            w_to;
   logic            w_done;
   logic [31:0]     w_rdata;

   assign w_gnt       = (r_state != IDLE);
   assign w_cur       = (r_state == GNT1);
   assign w_own_valid = (r_state == GNT0) ? m0_valid :
                        (r_state == GNT1) ? m1_valid : 1'b0;
   // Timeout fires on the last allowed cycle only if the slave is still silent.
   assign w_to        = (TIMEOUT != 0) && w_gnt && w_own_valid && !s_ready &&
                        (r_cnt == CW'(TIMEOUT - 1));
   assign w_done      = w_gnt && w_own_valid && (s_ready || w_to);
   assign w_rdata     = w_to ? ERR_DATA : s_rdata;

   assign grant      = {r_state == GNT1, r_state == GNT0};
   assign err        = w_to;
   assign err_master = w_to ? w_cur : r_err_master;
   assign m0_ready   = (r_state == GNT0) && (s_ready || w_to);
   assign m1_ready   = (r_state == GNT1) && (s_ready || w_to);
   assign m0_rdata   = (r_state == GNT0) ? w_rdata : 32'h0;
   assign m1_rdata   = (r_state == GNT1) ? w_rdata : 32'h0;

   always_comb begin
      s_valid = 1'b0;
      s_addr  = 32'h0;
      s_wdata = 32'h0;
      s_wstrb = 4'h0;
      case (r_state)
         GNT0: begin
            s_valid = m0_valid;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
         end
         GNT1: begin
            s_valid = m1_valid;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
         end
         default: ;
      endcase
   end

   // The finishing master is never re-granted directly; it must pass through IDLE.
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         IDLE: begin
            if (m0_valid && m1_valid) w_state_n = r_last ? GNT0 : GNT1;
            else if (m0_valid)        w_state_n = GNT0;
            else if (m1_valid)        w_state_n = GNT1;
         end
         GNT0: begin
            if (!m0_valid)   w_state_n = IDLE;
            else if (w_done) w_state_n = m1_valid ? GNT1 : IDLE;
         end
         GNT1: begin
            if (!m1_valid)   w_state_n = IDLE;
            else if (w_done) w_state_n = m0_valid ? GNT0 : IDLE;
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last       <= 1'b1;
         r_cnt        <= '0;
         r_err_master <= 1'b0;
      end else begin
         r_state <= w_state_n;
         if (w_done) r_last <= w_cur;
         if (w_to)   r_err_master <= w_cur;
         if (w_state_n != r_state)  r_cnt <= '0;
         else if (w_gnt && !s_ready) r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: arbitration, handover, round-robin, watchdog, reset.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_valid, m1_valid, m0_ready, m1_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
   logic        s_valid, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [1:0]  grant;
   logic        err, err_master;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
      .grant(grant), .err(err), .err_master(err_master)
   );

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      m0_valid = 1'b0; m1_valid = 1'b0;
      m0_addr  = 32'h100; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_addr  = 32'h200; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'hF;
      s_ready  = 1'b0; s_rdata = 32'h0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
      smp();
      total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
      total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_svalid got=%b exp=0", s_valid); end
      total++; if ({m0_ready, m1_ready, err, err_master} !== 4'b0) begin bad++; $display("FAIL reset_outs got=%b exp=0000", {m0_ready, m1_ready, err, err_master}); end
      do_reset();
   endtask

   task automatic test_single_read();
      m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
      smp();
      total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_req_cycle got=%b exp=00", grant); end
      tick();
      smp();
      total++; if (grant !== 2'b01 || s_valid !== 1'b1) begin bad++; $display("FAIL single_grant got=%b/%b exp=01/1", grant, s_valid); end
      total++; if (s_addr !== 32'h100 || s_wstrb !== 4'h0 || m0_ready !== 1'b0) begin bad++; $display("FAIL single_mux got=%h/%h/%b exp=100/0/0", s_addr, s_wstrb, m0_ready); end
      tick();
      s_ready = 1'b1; s_rdata = 32'h12345678;
      smp();
      total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h12345678) begin bad++; $display("FAIL single_ready got=%b/%h exp=1/12345678", m0_ready, m0_rdata); end
      total++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL single_m1 got=%b/%h exp=0/0", m1_ready, m1_rdata); end
      tick();
      m0_valid = 1'b0; s_ready = 1'b0;
      smp();
      total++; if (grant !== 2'b00 || s_valid !== 1'b0 || s_wstrb !== 4'h0) begin bad++; $display("FAIL single_idle got=%b/%b/%h exp=00/0/0", grant, s_valid, s_wstrb); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      s_ready = 1'b1; s_rdata = 32'h11112222;
      m0_valid = 1'b1; m1_valid = 1'b1;
      tick();
      smp();
      total++; if (grant !== 2'b01 || m0_ready !== 1'b1) begin bad++; $display("FAIL simul_first got=%b/%b exp=01/1", grant, m0_ready); end
      tick();
      m0_valid = 1'b0;
      smp();
      total++; if (grant !== 2'b10 || s_addr !== 32'h200 || s_wdata !== 32'hA5A5A5A5 || s_wstrb !== 4'hF || m1_ready !== 1'b1) begin bad++; $display("FAIL simul_second got=%b/%h/%h/%h/%b exp=10/200/a5a5a5a5/f/1", grant, s_addr, s_wdata, s_wstrb, m1_ready); end
      tick();
      m1_valid = 1'b0;
      smp();
      total++; if (grant !== 2'b00) begin bad++; $display("FAIL simul_idle got=%b exp=00", grant); end
      m0_valid = 1'b1; m1_valid = 1'b1;
      tick();
      smp();
      total++; if (grant !== 2'b01) begin bad++; $display("FAIL simul_repeat got=%b exp=01", grant); end
      tick();
      m0_valid = 1'b0;
      tick();
      m1_valid = 1'b0; s_ready = 1'b0;
   endtask

   task automatic test_alternate();
      logic [1:0] exp_g;
      do_reset();
      s_ready = 1'b1;
      m0_valid = 1'b1; m1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         smp();
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         total++; if (grant !== exp_g) begin bad++; $display("FAIL alternate_%0d got=%b exp=%b", i, grant, exp_g); end
      end
      m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      s_ready = 1'b0; s_rdata = 32'h55555555;
      m0_valid = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         smp();
         total++; if (s_valid !== 1'b1 || m0_ready !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL to_wait_%0d got=%b/%b/%b exp=1/0/0", i, s_valid, m0_ready, err); end
         tick();
      end
      smp();
      total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL to_ready got=%b/%h exp=1/deadbeef", m0_ready, m0_rdata); end
      total++; if (err !== 1'b1 || err_master !== 1'b0) begin bad++; $display("FAIL to_err got=%b/%b exp=1/0", err, err_master); end
      tick();
      m0_valid = 1'b0;
      smp();
      total++; if (s_valid !== 1'b0 || err !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL to_after got=%b/%b/%b exp=0/0/00", s_valid, err, grant); end
      m1_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      smp();
      total++; if (m1_ready !== 1'b1 || m1_rdata !== 32'hDEADBEEF || err !== 1'b1 || err_master !== 1'b1) begin bad++; $display("FAIL to_m1 got=%b/%h/%b/%b exp=1/deadbeef/1/1", m1_ready, m1_rdata, err, err_master); end
      tick();
      m1_valid = 1'b0;
      smp();
      total++; if (err !== 1'b0 || err_master !== 1'b1) begin bad++; $display("FAIL to_hold got=%b/%b exp=0/1", err, err_master); end
   endtask

   task automatic test_ready_at_limit();
      do_reset();
      s_ready = 1'b0;
      m0_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      s_ready = 1'b1; s_rdata = 32'hCAFE0001;
      smp();
      total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hCAFE0001 || err !== 1'b0) begin bad++; $display("FAIL limit_ready got=%b/%h/%b exp=1/cafe0001/0", m0_ready, m0_rdata, err); end
      tick();
      m0_valid = 1'b0; s_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_access();
      do_reset();
      s_ready = 1'b0;
      m1_valid = 1'b1;
      tick();
      smp();
      total++; if (grant !== 2'b10) begin bad++; $display("FAIL rstmid_pre got=%b exp=10", grant); end
      #1 rst_n = 1'b0;
      #1;
      total++; if (grant !== 2'b00 || s_valid !== 1'b0) begin bad++; $display("FAIL rstmid_now got=%b/%b exp=00/0", grant, s_valid); end
      tick();
      rst_n = 1'b1;
      tick();
      s_ready = 1'b1; s_rdata = 32'h0BADF00D;
      smp();
      total++; if (grant !== 2'b10 || m1_ready !== 1'b1 || m1_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL rstmid_serve got=%b/%b/%h exp=10/1/0badf00d", grant, m1_ready, m1_rdata); end
      tick();
      m1_valid = 1'b0; s_ready = 1'b0;
      do_reset();
      m0_valid = 1'b1; m1_valid = 1'b1;
      tick();
      smp();
      total++; if (grant !== 2'b01) begin bad++; $display("FAIL rstmid_prio got=%b exp=01", grant); end
      m0_valid = 1'b0; m1_valid = 1'b0;
   endtask

   initial begin
      do_reset();
      test_reset();
      test_single_read();
      test_simultaneous();
      test_alternate();
      test_timeout();
      test_ready_at_limit();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter sharing one native valid/ready memory port (picorv32 style) between the CPU and a second bus master, such as a VRAM blitter or DMA engine. It sits between the masters and the chip-select/read-mux fabric. Simultaneous requests are resolved by round-robin priority. A watchdog terminates slave accesses that never return ready, so a hung peripheral cannot stall the SoC.

## Interface
- TIMEOUT, 64: slave-response cycles allowed per access; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF: read data returned to the master on a timed-out access.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_valid, m1_valid  in  1  master request; held high until the matching m*_ready.
- m0_ready, m1_ready  out  1  access complete (combinational).
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 means read.
- m0_rdata, m1_rdata  out  32  read data; valid only while m*_ready is high.
- s_valid  out  1  request to the shared port.
- s_ready  in  1  slave completion.
- s_addr, s_wdata, s_wstrb  out  32/32/4  muxed from the granted master; s_wstrb is 0 when no master is granted.
- s_rdata  in  32  slave read data.
- grant  out  2  one-hot current owner; 2'b00 means idle.
- err  out  1  one-cycle pulse on a watchdog termination.
- err_master  out  1  index of the master that owned the last terminated access; holds until the next termination.

## Operation
- FSM states: IDLE, GNT0, GNT1. grant is {state==GNT1, state==GNT0}.
- Priority register `last` holds the index of the most recently granted master; its reset value is 1, so m0 wins the first tie.
- IDLE:
  - only m0_valid high -> GNT0.
  - only m1_valid high -> GNT1.
  - both high -> grant the master that is not `last`.
- In GNTx:
  - s_valid = mx_valid; s_addr/s_wdata/s_wstrb = master x signals.
  - mx_ready = s_ready; mx_rdata = s_rdata.
  - The non-granted master sees ready=0; its rdata is don't-care and driven 0.
- Completion (s_ready high in GNTx): update `last`=x. Next state is GNTy if my_valid is high, else IDLE. Never re-grant x directly; its valid drops on the following cycle.
- mx_valid low while in GNTx (master aborted or was reset): return to IDLE and do not update `last`.
- Watchdog:
  - Counter of width $clog2(TIMEOUT+1) clears on entry to each GNT state and increments on every GNT cycle with s_ready low.
  - On the cycle the count equals TIMEOUT-1 with s_ready still low, the arbiter forces mx_ready=1 and mx_rdata=ERR_DATA, and pulses err with err_master=x.
  - That cycle then follows the normal completion transition.
  - If s_ready is high in the same cycle, it is a normal completion: no err, slave data is returned.
- Reset values: state IDLE, last 1, counter 0, grant 0, err 0, err_master 0, s_valid 0, all m*_ready 0.
- Assertion of rst_n low during a GNT state forces IDLE immediately, regardless of any in-flight access.

## Timing
- Arbitration latency: request at cycle N with the arbiter in IDLE -> s_valid at N+1.
- Handover: completion at cycle M with the other master pending -> that master's s_valid at M+1, with no idle cycle.
- Same-master back-to-back access has at least one idle cycle, because the arbiter returns to IDLE before re-granting.
- Ready and read-data paths are combinational. The slave sees the same single-cycle and registered-ready behaviour as a direct connection.
- Timed-out access: m*_ready arrives TIMEOUT cycles after the first s_valid cycle.
- The slave must tolerate s_valid dropping without s_ready; after a timeout, s_valid is low on the next cycle.

## Test plan
- Single m0 read, slave ready after 1 cycle, s_rdata=32'h12345678 -> grant=01 one cycle after m0_valid; m0_ready with m0_rdata=12345678; m1_ready stays 0.
- m0 and m1 request in the same cycle after reset -> m0 served first, then m1 on the next cycle with no idle gap; repeat the simultaneous request -> m0 first again, since `last`=1 after m1.
- m0 issues continuous back-to-back requests while m1 is held pending -> grants alternate 01,10,01,...; m1 is never starved.
- Slave never asserts ready, TIMEOUT=4 -> m0_ready with m0_rdata=DEADBEEF 4 cycles after s_valid rises; err pulses one cycle with err_master=0; s_valid low next cycle.
- s_ready arrives exactly on the TIMEOUT-th cycle -> slave data is returned and err stays 0.
- rst_n asserted low mid-access in GNT1 -> grant=00 and s_valid=0 immediately; after release, m1 request is served normally with m0 priority restored.
